ahb_apb_bridge_ctrl: RTL and testbench

Control FSM that sequences AHB-Lite transfers onto the APB4 bus of the AHB-to-APB bridge. It decodes the target APB slave from the AHB address and runs the APB SETUP and ACCESS phases. It stretches the AHB data phase with hreadyout, returns read data, and generates the AHB two-cycle ERROR response for unmapped addresses, illegal sizes, pslverr and timeouts. Single clock domain; the bridge datapath and the APB slaves run on hclk.

---
 rtl/ahb_apb_pkg.sv | 32 +++
 rtl/apb_slv_decoder.sv | 30 +++
 rtl/ahb_apb_bridge_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ahb_apb_bridge_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared AHB encodings and bridge state type for the AHB-to-APB
//               bridge control path.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic [1:0] c_hresp_okay  = 2'b00;
    localparam logic [1:0] c_hresp_error = 2'b01;

    localparam logic [2:0] c_hsize_byte = 3'b000;
    localparam logic [2:0] c_hsize_half = 3'b001;
    localparam logic [2:0] c_hsize_word = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_slv_decoder.sv
`default_nettype none
// ============================================================================
// Module      : apb_slv_decoder
// Description : Maps the slave-index address field to a one-hot APB select
//               and flags indices with no slave behind them.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slv_decoder #(
    parameter int NUM_SLV = 3,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]   i_idx,
    output logic [NUM_SLV-1:0] o_sel,
    output logic               o_unmapped
);

    logic [31:0] w_idx;

    assign w_idx = 32'(i_idx);

    generate
        for (genvar g = 0; g < NUM_SLV; g++) begin : g_sel
            assign o_sel[g] = (w_idx == g);
        end
    endgenerate

    assign o_unmapped = (w_idx >= NUM_SLV);

endmodule
`default_nettype wire

// File: rtl/ahb_apb_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_bridge_ctrl
// Description : Sequences AHB-Lite transfers into APB4 SETUP/ACCESS phases,
//               stretching the AHB data phase and raising ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_apb_bridge_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int SEL_LSB = 12,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                hsel,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic [DATA_W-1:0]   hwdata,
    input  logic                hreadyin,
    output logic                hreadyout,
    output logic [1:0]          hresp,
    output logic [DATA_W-1:0]   hrdata,
    output logic [NUM_SLV-1:0]  psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    import ahb_apb_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    bridge_state_t       r_state;
    bridge_state_t       w_next;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [2:0]          r_hsize;
    logic [NUM_SLV-1:0]  r_sel;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W-1:0]   r_hrdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_SLV-1:0]  w_dec_sel;
    logic                w_unmapped;
    logic                w_accept;
    logic                w_bad_size;
    logic [STRB_W-1:0]   w_strb;
    logic                w_unused_htrans;

    // SEQ and NONSEQ both carry a transfer; only bit 1 matters here.
    assign w_accept        = hsel & hreadyin & htrans[1];
    assign w_unused_htrans = htrans[0];
    assign w_bad_size      = (hsize > c_hsize_word);

    apb_slv_decoder #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_dec (
        .i_idx      (haddr[SEL_LSB +: IDX_W]),
        .o_sel      (w_dec_sel),
        .o_unmapped (w_unmapped)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_hsize  <= '0;
            r_sel    <= '0;
            r_pwdata <= '0;
            r_hrdata <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_paddr  <= haddr;
                r_pwrite <= hwrite;
                r_hsize  <= hsize;
                r_sel    <= w_dec_sel;
            end
            if (r_state == S_WDATA) begin
                r_pwdata <= hwdata;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_ACCESS && pready && !pslverr && !r_pwrite) begin
                r_hrdata <= prdata;
            end
        end
    end

    // Strobes derive from registered size/address, so they stay stable
    // for the whole APB transfer.
    always_comb begin
        w_strb = '0;
        case (r_hsize)
            c_hsize_byte: w_strb = STRB_W'(1) << r_paddr[1:0];
            c_hsize_half: w_strb = STRB_W'(3) << {r_paddr[1], 1'b0};
            default:      w_strb = '1;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = c_hresp_okay;
        psel      = '0;
        penable   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad_size || w_unmapped) begin
                        w_next = S_ERR1;
                    end else if (hwrite) begin
                        w_next = S_WDATA;
                    end else begin
                        w_next = S_SETUP;
                    end
                end
            end
            S_WDATA: begin
                hreadyout = 1'b0;
                w_next    = S_SETUP;
            end
            S_SETUP: begin
                hreadyout = 1'b0;
                psel      = r_sel;
                w_next    = S_ACCESS;
            end
            S_ACCESS: begin
                hreadyout = 1'b0;
                psel      = r_sel;
                penable   = 1'b1;
                if (pready) begin
                    w_next = pslverr ? S_ERR1 : S_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_next = S_ERR1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = c_hresp_error;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                hresp  = c_hresp_error;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign paddr  = r_paddr;
    assign pwrite = r_pwrite;
    assign pwdata = r_pwdata;
    assign pstrb  = r_pwrite ? w_strb : '0;
    assign hrdata = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_apb_bridge_ctrl
// Description : Directed self-checking bench for the AHB-to-APB bridge control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_apb_bridge_ctrl;

    import ahb_apb_pkg::*;

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_err = 0;
    int n_chk = 0;

    ahb_apb_bridge_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .NUM_SLV (3),
        .SEL_LSB (12),
        .IDX_W   (2),
        .TIMEOUT (16)
    ) u_dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hreadyin  (hreadyin),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = c_htrans_nonseq;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic ahb_idle();
        hsel   = 1'b0;
        htrans = c_htrans_idle;
    endtask

    initial begin
        int waits;
        int acc;
        hresetn  = 1'b0;
        hsel     = 1'b0;
        htrans   = c_htrans_idle;
        hwrite   = 1'b0;
        hsize    = c_hsize_word;
        haddr    = '0;
        hwdata   = '0;
        hreadyin = 1'b1;
        prdata   = '0;
        pready   = 1'b1;
        pslverr  = 1'b0;

        tick();
        tick();
        chk("rst_hreadyout", hreadyout, 1);
        chk("rst_hresp",     hresp,     0);
        chk("rst_psel",      psel,      0);
        chk("rst_penable",   penable,   0);
        chk("rst_paddr",     paddr,     0);
        chk("rst_pstrb",     pstrb,     0);
        chk("rst_hrdata",    hrdata,    0);
        hresetn = 1'b1;
        tick();

        // BUSY transfer must be ignored
        hsel   = 1'b1;
        htrans = c_htrans_busy;
        haddr  = 32'h0000_1000;
        tick();
        chk("busy_hready", hreadyout, 1);
        chk("busy_psel",   psel,      0);
        tick();
        chk("busy_psel2",  psel,      0);
        ahb_idle();

        // Single read, zero wait states
        prdata = 32'hDEAD_BEEF;
        pready = 1'b1;
        ahb_addr(32'h0000_1004, 1'b0, c_hsize_word);
        chk("rd_t0_hready", hreadyout, 1);
        tick();
        ahb_idle();
        chk("rd_t1_psel",    psel,      3'b010);
        chk("rd_t1_penable", penable,   0);
        chk("rd_t1_hready",  hreadyout, 0);
        chk("rd_t1_paddr",   paddr,     32'h0000_1004);
        chk("rd_t1_pwrite",  pwrite,    0);
        chk("rd_t1_pstrb",   pstrb,     0);
        tick();
        chk("rd_t2_psel",    psel,      3'b010);
        chk("rd_t2_penable", penable,   1);
        chk("rd_t2_hready",  hreadyout, 0);
        tick();
        chk("rd_t3_hready",  hreadyout, 1);
        chk("rd_t3_hresp",   hresp,     0);
        chk("rd_t3_hrdata",  hrdata,    32'hDEAD_BEEF);
        chk("rd_t3_psel",    psel,      0);
        prdata = '0;
        tick();
        chk("rd_hold_hrdata", hrdata, 32'hDEAD_BEEF);

        // Halfword write with two low-pready ACCESS cycles
        pready = 1'b0;
        ahb_addr(32'h0000_0002, 1'b1, c_hsize_half);
        tick();
        ahb_idle();
        hwdata = 32'h1234_0000;
        chk("hw_wdata_hready", hreadyout, 0);
        waits = 1;
        acc   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hwdata = 32'hFFFF_FFFF;
            if (hreadyout) break;
            waits++;
            if (psel != 0) begin
                chk("hw_psel",   psel,   3'b001);
                chk("hw_pstrb",  pstrb,  4'b1100);
                chk("hw_pwdata", pwdata, 32'h1234_0000);
                chk("hw_pwrite", pwrite, 1);
            end
            if (penable) begin
                acc++;
                pready = (acc > 2);
            end
        end
        chk("hw_waits", waits, 5);
        chk("hw_hresp", hresp, 0);
        pready = 1'b1;

        // Unmapped read
        ahb_addr(32'h0000_3000, 1'b0, c_hsize_word);
        tick();
        ahb_idle();
        chk("um_e1_hready", hreadyout, 0);
        chk("um_e1_hresp",  hresp,     c_hresp_error);
        chk("um_e1_psel",   psel,      0);
        tick();
        chk("um_e2_hready", hreadyout, 1);
        chk("um_e2_hresp",  hresp,     c_hresp_error);
        chk("um_e2_psel",   psel,      0);
        tick();
        chk("um_done_hresp", hresp, 0);
        chk("um_done_psel",  psel,  0);

        // Illegal size to a mapped slave
        ahb_addr(32'h0000_1000, 1'b0, 3'b011);
        tick();
        ahb_idle();
        chk("sz_e1_hresp",  hresp,     c_hresp_error);
        chk("sz_e1_hready", hreadyout, 0);
        chk("sz_e1_psel",   psel,      0);
        tick();
        tick();

        // Word write answered with pslverr
        ahb_addr(32'h0000_2008, 1'b1, c_hsize_word);
        tick();
        ahb_idle();
        hwdata = 32'hA5A5_A5A5;
        tick();
        chk("se_setup_psel",   psel,   3'b100);
        chk("se_setup_pstrb",  pstrb,  4'b1111);
        chk("se_setup_pwdata", pwdata, 32'hA5A5_A5A5);
        pready  = 1'b1;
        pslverr = 1'b1;
        tick();
        chk("se_acc_penable", penable, 1);
        tick();
        pslverr = 1'b0;
        chk("se_e1_hready",  hreadyout, 0);
        chk("se_e1_hresp",   hresp,     c_hresp_error);
        chk("se_e1_psel",    psel,      0);
        chk("se_e1_penable", penable,   0);
        tick();
        chk("se_e2_hready", hreadyout, 1);
        chk("se_e2_hresp",  hresp,     c_hresp_error);
        tick();

        // Byte write to the top lane
        ahb_addr(32'h0000_1003, 1'b1, c_hsize_byte);
        tick();
        ahb_idle();
        hwdata = 32'h7700_0000;
        tick();
        chk("bw_pstrb", pstrb, 4'b1000);
        chk("bw_psel",  psel,  3'b010);
        tick();
        tick();
        chk("bw_done_hready", hreadyout, 1);
        chk("bw_done_hresp",  hresp,     0);

        // Timeout with pready held low
        pready = 1'b0;
        ahb_addr(32'h0000_0000, 1'b0, c_hsize_word);
        tick();
        ahb_idle();
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hresp == c_hresp_error) break;
            if (penable) acc++;
        end
        chk("to_access_cycles", acc,       16);
        chk("to_e1_psel",       psel,      0);
        chk("to_e1_hready",     hreadyout, 0);
        chk("to_e1_hresp",      hresp,     c_hresp_error);
        chk("to_hrdata_hold",   hrdata,    32'hDEAD_BEEF);
        tick();
        tick();
        pready = 1'b1;

        // Back-to-back reads, then reset during ACCESS
        prdata = 32'h1111_1111;
        ahb_addr(32'h0000_0010, 1'b0, c_hsize_word);
        tick();
        ahb_idle();
        chk("bb1_psel", psel, 3'b001);
        tick();
        tick();
        chk("bb1_hready", hreadyout, 1);
        chk("bb1_hrdata", hrdata,    32'h1111_1111);
        ahb_addr(32'h0000_2020, 1'b0, c_hsize_word);
        prdata = 32'h2222_2222;
        tick();
        ahb_idle();
        chk("bb2_psel",  psel,  3'b100);
        chk("bb2_paddr", paddr, 32'h0000_2020);
        tick();
        chk("bb2_penable", penable, 1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("arst_psel",    psel,      0);
        chk("arst_penable", penable,   0);
        chk("arst_hready",  hreadyout, 1);
        chk("arst_hresp",   hresp,     0);
        chk("arst_hrdata",  hrdata,    0);
        tick();
        hresetn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
